// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared types for the tiled convolution controller.
// FSM state enum, layer config struct and loop-order counter slots.
package conv_ctrl_pkg;

  localparam int CFG_W = 16;
  localparam int NLOOP = 6;

  // Counter chain order, innermost first
  localparam int LP_KX = 0;
  localparam int LP_KY = 1;
  localparam int LP_CO = 2;
  localparam int LP_CI = 3;
  localparam int LP_Y  = 4;
  localparam int LP_X  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] w;
    logic [CFG_W-1:0] h;
    logic [CFG_W-1:0] in_ch;
    logic [CFG_W-1:0] out_ch;
    logic [CFG_W-1:0] k;
    logic [CFG_W-1:0] tile_w;
  } conv_cfg_t;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: one loop counter of the convolution nest.
// en advances, clr zeroes, wraps to 0 after max; wrap flags cnt==max.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n_in,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == max);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv_ctrl_tiled.sv
// conv_ctrl_tiled: tiled 6-deep conv loop sequencer with operand
// handshake, MAC control, psum memory strobes and output tagging.
module conv_ctrl_tiled
  import conv_ctrl_pkg::*;
#(
  parameter int MAX_FM_W = 1024,
  parameter int MAX_FM_H = 1024,
  parameter int MAX_CH   = 64,
  parameter int MAX_K    = 7,
  parameter int CNT_W    = CFG_W,
  parameter int PSUM_AW  = 6
) (
  input  logic               clk,
  input  logic               arst_n_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_w,
  input  logic [CNT_W-1:0]   cfg_h,
  input  logic [CNT_W-1:0]   cfg_in_ch,
  input  logic [CNT_W-1:0]   cfg_out_ch,
  input  logic [CNT_W-1:0]   cfg_k,
  input  logic [CNT_W-1:0]   cfg_tile_w,
  output logic               running,
  output logic               cfg_err,
  input  logic               data_ready,
  input  logic               a_valid,
  input  logic               b_valid,
  output logic               a_ready,
  output logic               b_ready,
  output logic               int_mem_re,
  output logic               write_a,
  output logic               write_b,
  output logic [CNT_W-1:0]   kx_out,
  output logic [CNT_W-1:0]   ky_out,
  output logic [CNT_W-1:0]   inch_out,
  output logic [CNT_W-1:0]   outch_out,
  output logic [CNT_W-1:0]   x_out,
  output logic [CNT_W-1:0]   y_out,
  output logic               mac_valid,
  output logic               mac_accumulate_internal,
  output logic               mac_accumulate_with_0,
  output logic               mem_re,
  output logic               mem_we,
  output logic [PSUM_AW-1:0] mem_read_addr,
  output logic [PSUM_AW-1:0] mem_write_addr,
  output logic               output_valid,
  output logic [CNT_W-1:0]   output_x,
  output logic [CNT_W-1:0]   output_y,
  output logic [CNT_W-1:0]   output_ch,
  output logic               tile_done,
  output logic               layer_done
);

  ctrl_state_t state_q, state_d;
  conv_cfg_t   cfg_q, cfg_d;

  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] rem, cur_tw, km1;
  logic             cfg_ok, accept;
  logic             step, tile_end, last_tile;

  logic [NLOOP-1:0] cen, cwrap;
  logic [CNT_W-1:0] cmax [NLOOP];
  logic [CNT_W-1:0] cval [NLOOP];

  logic             mac_valid_q;
  logic [CNT_W-1:0] mac_kx_q, mac_ky_q, mac_ci_q;
  logic [CNT_W-1:0] mac_co_q, mac_x_q, mac_y_q;
  logic             mac_last_kk, mac_last_all;

  logic               cfg_err_q;
  logic               mem_we_q;
  logic [PSUM_AW-1:0] mem_waddr_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   out_x_q, out_y_q, out_ch_q;

  always_comb begin
    cfg_ok = (cfg_w != '0) && (cfg_h != '0)
          && (cfg_in_ch != '0) && (cfg_out_ch != '0)
          && (cfg_k != '0) && (cfg_tile_w != '0)
          && (cfg_w <= CNT_W'(MAX_FM_W))
          && (cfg_h <= CNT_W'(MAX_FM_H))
          && (cfg_in_ch <= CNT_W'(MAX_CH))
          && (cfg_out_ch <= CNT_W'(MAX_CH))
          && (cfg_k <= CNT_W'(MAX_K))
          && (cfg_tile_w <= cfg_w);
  end

  // Current tile is clipped to the columns left in the layer
  always_comb begin
    rem       = cfg_q.w - base_q;
    last_tile = (rem <= cfg_q.tile_w);
    cur_tw    = last_tile ? rem : cfg_q.tile_w;
    km1       = cfg_q.k - 1'b1;
  end

  always_comb begin
    cmax[LP_KX] = km1;
    cmax[LP_KY] = km1;
    cmax[LP_CO] = cfg_q.out_ch - 1'b1;
    cmax[LP_CI] = cfg_q.in_ch - 1'b1;
    cmax[LP_Y]  = cfg_q.h - 1'b1;
    cmax[LP_X]  = cur_tw - 1'b1;
  end

  always_comb begin
    cen[0] = step;
    for (int i = 1; i < NLOOP; i++)
      cen[i] = cen[i-1] & cwrap[i-1];
  end

  assign tile_end = cen[LP_X] & cwrap[LP_X];

  for (genvar i = 0; i < NLOOP; i++) begin : g_cnt
    wrap_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .en        (cen[i]),
      .clr       (accept),
      .max       (cmax[i]),
      .cnt       (cval[i]),
      .wrap      (cwrap[i])
    );
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && cfg_ok) state_d = ST_LOAD;
      ST_LOAD:  if (data_ready) state_d = ST_RUN;
      ST_RUN:   if (tile_end) state_d = ST_DRAIN;
      ST_DRAIN: state_d = last_tile ? ST_IDLE : ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running    = (state_q != ST_IDLE);
    a_ready    = (state_q == ST_RUN);
    b_ready    = a_ready;
    step       = a_ready && a_valid && b_valid;
    tile_done  = (state_q == ST_DRAIN);
    layer_done = tile_done && last_tile;
    accept     = (state_q == ST_IDLE) && start && cfg_ok;
  end

  always_comb begin
    cfg_d  = cfg_q;
    base_d = base_q;
    if (accept) begin
      cfg_d = '{w: cfg_w, h: cfg_h, in_ch: cfg_in_ch,
                out_ch: cfg_out_ch, k: cfg_k,
                tile_w: cfg_tile_w};
      base_d = '0;
    end else if (tile_done && !last_tile) begin
      base_d = base_q + cfg_q.tile_w;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      cfg_q     <= '0;
      base_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      base_q    <= base_d;
      cfg_err_q <= (state_q == ST_IDLE) && start && !cfg_ok;
    end
  end

  assign kx_out     = cval[LP_KX];
  assign ky_out     = cval[LP_KY];
  assign inch_out   = cval[LP_CI];
  assign outch_out  = cval[LP_CO];
  assign y_out      = cval[LP_Y];
  assign x_out      = base_q + cval[LP_X];
  assign int_mem_re = step;
  assign write_a    = step;
  assign write_b    = step;
  assign cfg_err    = cfg_err_q;

  // A new psum group starts at kx=ky=0: fetch its running sum
  assign mem_re = step && (cval[LP_KX] == '0)
               && (cval[LP_KY] == '0);
  assign mem_read_addr = cval[LP_CO][PSUM_AW-1:0];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mac_valid_q <= 1'b0;
      mac_kx_q    <= '0;
      mac_ky_q    <= '0;
      mac_ci_q    <= '0;
      mac_co_q    <= '0;
      mac_x_q     <= '0;
      mac_y_q     <= '0;
    end else begin
      mac_valid_q <= step;
      if (step) begin
        mac_kx_q <= kx_out;
        mac_ky_q <= ky_out;
        mac_ci_q <= inch_out;
        mac_co_q <= outch_out;
        mac_x_q  <= x_out;
        mac_y_q  <= y_out;
      end
    end
  end

  always_comb begin
    mac_last_kk  = mac_valid_q && (mac_kx_q == km1)
                && (mac_ky_q == km1);
    mac_last_all = mac_last_kk
                && (mac_ci_q == cfg_q.in_ch - 1'b1);
  end

  // Gated by mac_valid so idle/reset cycles drive all zeros
  assign mac_valid = mac_valid_q;
  assign mac_accumulate_internal = mac_valid_q
    && !((mac_kx_q == '0) && (mac_ky_q == '0));
  assign mac_accumulate_with_0 = mac_valid_q
    && (mac_ci_q == '0) && (mac_kx_q == '0)
    && (mac_ky_q == '0);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_ch_q    <= '0;
    end else begin
      mem_we_q    <= mac_last_kk;
      out_valid_q <= mac_last_all;
      if (mac_last_kk)
        mem_waddr_q <= mac_co_q[PSUM_AW-1:0];
      if (mac_last_all) begin
        out_x_q  <= mac_x_q;
        out_y_q  <= mac_y_q;
        out_ch_q <= mac_co_q;
      end
    end
  end

  assign mem_we         = mem_we_q;
  assign mem_write_addr = mem_waddr_q;
  assign output_valid   = out_valid_q;
  assign output_x       = out_x_q;
  assign output_y       = out_y_q;
  assign output_ch      = out_ch_q;

endmodule

// File: tb/tb_conv_ctrl_tiled.sv
// tb_conv_ctrl_tiled: scoreboard bench for conv_ctrl_tiled.
// Loop-nest model fills queues; a negedge monitor pops and compares.
module tb_conv_ctrl_tiled;

  localparam int CW = 16;
  localparam int AW = 6;

  typedef struct {
    int kx; int ky; int ci; int co; int x; int y;
  } tup_t;

  typedef struct {
    int x; int y; int ch;
  } opix_t;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] cfg_w = '0, cfg_h = '0, cfg_in_ch = '0;
  logic [CW-1:0] cfg_out_ch = '0, cfg_k = '0, cfg_tile_w = '0;
  logic data_ready = 1'b0, a_valid = 1'b0, b_valid = 1'b0;

  logic running, cfg_err, a_ready, b_ready;
  logic int_mem_re, write_a, write_b;
  logic [CW-1:0] kx_out, ky_out, inch_out, outch_out, x_out, y_out;
  logic mac_valid, mac_accumulate_internal, mac_accumulate_with_0;
  logic mem_re, mem_we;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic output_valid;
  logic [CW-1:0] output_x, output_y, output_ch;
  logic tile_done, layer_done;

  conv_ctrl_tiled dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_in_ch(cfg_in_ch),
    .cfg_out_ch(cfg_out_ch), .cfg_k(cfg_k),
    .cfg_tile_w(cfg_tile_w),
    .running(running), .cfg_err(cfg_err),
    .data_ready(data_ready), .a_valid(a_valid),
    .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .int_mem_re(int_mem_re), .write_a(write_a),
    .write_b(write_b),
    .kx_out(kx_out), .ky_out(ky_out), .inch_out(inch_out),
    .outch_out(outch_out), .x_out(x_out), .y_out(y_out),
    .mac_valid(mac_valid),
    .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr),
    .output_valid(output_valid), .output_x(output_x),
    .output_y(output_y), .output_ch(output_ch),
    .tile_done(tile_done), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  tup_t  step_q[$];
  opix_t out_q[$];
  int    wa_q[$];
  int    td_q[$];

  bit active = 1'b0;
  int cur_k, cur_ci;
  int mac_cnt, tile_cnt, layer_cnt, max_x;

  bit s1_step, s1_last, s1_lci, s1_ai, s1_w0;
  bit s2_last, s2_lci;
  bit c_step, c_last, c_lci, c_ai, c_w0;
  tup_t  mt;
  opix_t mo;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event", nm);
  endtask

  always @(negedge clk) begin
    if (!active) begin
      s1_step = 0; s1_last = 0; s1_lci = 0;
      s1_ai = 0; s1_w0 = 0; s2_last = 0; s2_lci = 0;
    end else begin
      c_step = 0; c_last = 0; c_lci = 0; c_ai = 0; c_w0 = 0;
      chk("strobes", {write_a, write_b},
          {int_mem_re, int_mem_re});
      if (int_mem_re) begin
        if (step_q.size() == 0) fail("extra_step");
        else begin
          mt = step_q.pop_front();
          chk("kx", kx_out, mt.kx);
          chk("ky", ky_out, mt.ky);
          chk("ci", inch_out, mt.ci);
          chk("co", outch_out, mt.co);
          chk("x", x_out, mt.x);
          chk("y", y_out, mt.y);
          chk("mem_re", mem_re, mt.kx == 0 && mt.ky == 0);
          if (mem_re) chk("raddr", mem_read_addr, mt.co);
          c_step = 1;
          c_last = (mt.kx == cur_k - 1) && (mt.ky == cur_k - 1);
          c_lci  = c_last && (mt.ci == cur_ci - 1);
          c_ai   = !(mt.kx == 0 && mt.ky == 0);
          c_w0   = mt.ci == 0 && mt.kx == 0 && mt.ky == 0;
          if (int'(x_out) > max_x) max_x = int'(x_out);
        end
      end else if (a_ready && step_q.size() > 0) begin
        chk("hold_kx", kx_out, step_q[0].kx);
        chk("hold_x", x_out, step_q[0].x);
      end
      chk("mac_valid", mac_valid, s1_step);
      if (mac_valid) begin
        mac_cnt++;
        chk("acc_int", mac_accumulate_internal, s1_ai);
        chk("acc_w0", mac_accumulate_with_0, s1_w0);
      end
      chk("mem_we", mem_we, s2_last);
      if (mem_we) begin
        if (wa_q.size() == 0) fail("extra_we");
        else chk("waddr", mem_write_addr, wa_q.pop_front());
      end
      chk("out_valid", output_valid, s2_lci);
      if (output_valid) begin
        if (out_q.size() == 0) fail("extra_out");
        else begin
          mo = out_q.pop_front();
          chk("out_x", output_x, mo.x);
          chk("out_y", output_y, mo.y);
          chk("out_ch", output_ch, mo.ch);
        end
      end
      if (tile_done) begin
        tile_cnt++;
        if (td_q.size() == 0) fail("extra_tile");
        else chk("tile_macs", mac_cnt, td_q.pop_front());
      end
      if (layer_done) begin
        layer_cnt++;
        chk("layer_tile", tile_done, 1);
        chk("layer_last", td_q.size(), 0);
      end
      s2_last = s1_last; s2_lci = s1_lci;
      s1_last = c_last;  s1_lci = c_lci;
      s1_step = c_step;  s1_ai = c_ai; s1_w0 = c_w0;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_idx"},
        {kx_out, ky_out, inch_out, outch_out}, 0);
    chk({nm, "_pos"}, {x_out, y_out, output_x, output_y}, 0);
    chk({nm, "_ctl"},
        {output_ch, mem_read_addr, mem_write_addr, running,
         cfg_err, a_ready, b_ready, int_mem_re, write_a,
         write_b, mac_valid, mac_accumulate_internal,
         mac_accumulate_with_0, mem_re, mem_we, output_valid,
         tile_done, layer_done}, 0);
  endtask

  task automatic drive_cfg(input int w, h, ci, co, k, tw);
    cfg_w = CW'(w); cfg_h = CW'(h); cfg_in_ch = CW'(ci);
    cfg_out_ch = CW'(co); cfg_k = CW'(k); cfg_tile_w = CW'(tw);
  endtask

  task automatic run_layer(input int w, h, ci, co, k, tw,
                           input int mode, input int abort_at);
    int base, ctw, macs, tiles, cyc;
    bit done;
    step_q.delete(); out_q.delete();
    wa_q.delete(); td_q.delete();
    base = 0; macs = 0; tiles = 0;
    while (base < w) begin
      ctw = (w - base < tw) ? w - base : tw;
      for (int xl = 0; xl < ctw; xl++)
        for (int yy = 0; yy < h; yy++)
          for (int i = 0; i < ci; i++)
            for (int o = 0; o < co; o++)
              for (int ky = 0; ky < k; ky++)
                for (int kx = 0; kx < k; kx++) begin
                  step_q.push_back(tup_t'{kx: kx, ky: ky, ci: i,
                    co: o, x: base + xl, y: yy});
                  macs++;
                  if (kx == k - 1 && ky == k - 1) begin
                    wa_q.push_back(o);
                    if (i == ci - 1)
                      out_q.push_back(opix_t'{x: base + xl,
                        y: yy, ch: o});
                  end
                end
      td_q.push_back(macs);
      tiles++;
      base += tw;
    end
    cur_k = k; cur_ci = ci;
    mac_cnt = 0; tile_cnt = 0; layer_cnt = 0; max_x = 0;
    @(posedge clk); #1;
    drive_cfg(w, h, ci, co, k, tw);
    start = 1; active = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0; done = 0;
    while (!done && cyc < 20000) begin
      case (mode)
        0: begin a_valid = 1; b_valid = 1; data_ready = 1; end
        1: begin
          a_valid = 1; b_valid = (cyc % 3) != 2; data_ready = 1;
        end
        default: begin
          a_valid = $urandom_range(0, 3) != 0;
          b_valid = $urandom_range(0, 3) != 0;
          data_ready = $urandom_range(0, 1) != 0;
        end
      endcase
      @(negedge clk);
      if (layer_done) done = 1;
      if (abort_at > 0 && cyc == abort_at) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (abort_at > 0 && !done) begin
      #1;
      active = 0;
      arst_n_in = 0;
      @(negedge clk);
      check_zero("mid_rst");
      @(posedge clk); #1;
      arst_n_in = 1;
      a_valid = 0; b_valid = 0; data_ready = 0;
      return;
    end
    #1;
    a_valid = 0; b_valid = 0; data_ready = 0;
    if (!done) fail("timeout");
    repeat (3) @(negedge clk);
    chk("macs", mac_cnt, macs);
    chk("tiles", tile_cnt, tiles);
    chk("layers", layer_cnt, 1);
    chk("steps_left", step_q.size(), 0);
    chk("outs_left", out_q.size(), 0);
    chk("we_left", wa_q.size(), 0);
    chk("max_x", max_x, w - 1);
    chk("idle", running, 0);
    #1;
    active = 0;
  endtask

  task automatic try_bad(input int w, h, ci, co, k, tw);
    int n, r;
    @(posedge clk); #1;
    drive_cfg(w, h, ci, co, k, tw);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0; r = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(cfg_err);
      r += int'(running);
    end
    chk("cfg_err_pulses", n, 1);
    chk("cfg_err_running", r, 0);
  endtask

  initial begin
    int rw, rtw;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    arst_n_in = 1;

    run_layer(4, 2, 2, 2, 3, 2, 0, 0);
    run_layer(4, 2, 2, 2, 3, 3, 0, 0);
    run_layer(4, 2, 2, 2, 3, 2, 1, 0);
    try_bad(4, 2, 2, 2, 0, 2);
    try_bad(4, 2, 2, 2, 3, 5);
    run_layer(3, 2, 1, 1, 1, 2, 0, 0);
    run_layer(4, 2, 2, 2, 3, 2, 0, 100);
    run_layer(4, 2, 2, 2, 3, 2, 0, 0);

    repeat (6) begin
      rw  = $urandom_range(1, 5);
      rtw = $urandom_range(1, rw);
      run_layer(rw, $urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(1, 3),
                rtw, 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
